minterm_scan_ctrl: RTL and testbench

//   Sequencer that sweeps every input combination of a combinational

---
 rtl/minterm_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_minterm_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_scan_ctrl.sv
// Sweeps every input vector of an N_IN-input netlist, waits SETTLE cycles per vector,
// samples its single output and streams the indices of vectors where it is 1.
module minterm_scan_ctrl #(
  parameter int N_IN   = 14,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            f_in,
  output logic            mt_valid,
  input  logic            mt_ready,
  output logic [N_IN-1:0] mt_index,
  output logic [N_IN:0]   mt_count,
  output logic            busy,
  output logic            done
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]      r_state;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_index;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_count;

  logic w_last;
  logic w_handshake;
  logic w_advance;

  assign w_last      = (r_vec == {N_IN{1'b1}});
  assign w_handshake = (r_state == S_EMIT) && r_valid && mt_ready;
  // Move to the next vector after a zero sample or a delivered minterm.
  assign w_advance   = ((r_state == S_SAMPLE) && !f_in) || w_handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_index <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Abort beats a same-cycle handshake; count and vector are left as they were.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_vec   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SAMPLE: begin
          if (f_in) begin
            r_state <= S_EMIT;
            r_valid <= 1'b1;
            r_index <= r_vec;
            r_count <= r_count + (N_IN+1)'(1);
          end
        end
        S_EMIT: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_advance) begin
        if (w_last) begin
          r_state <= S_FIN;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_vec   <= r_vec + N_IN'(1);
          r_cnt   <= CNT_LOAD;
          r_state <= S_WAIT;
        end
      end
    end
  end

  assign vec_out  = r_vec;
  assign mt_valid = r_valid;
  assign mt_index = r_index;
  assign mt_count = r_count;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Bench for minterm_scan_ctrl: a 4-input instance checked every cycle against a sweep-level
// model, and a 14-input instance checked against a software truth table.
module tb_minterm_scan_ctrl;

  localparam int N4  = 4;
  localparam int S4  = 2;
  localparam int N14 = 14;
  localparam int S14 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start4 = 1'b0, abort4 = 1'b0, ready4 = 1'b0, f4;
  logic [N4-1:0] vec4, idx4;
  logic valid4, busy4, done4;
  logic [N4:0] cnt4;

  logic start14 = 1'b0, abort14 = 1'b0, ready14 = 1'b0, f14;
  logic [N14-1:0] vec14, idx14;
  logic valid14, busy14, done14;
  logic [N14:0] cnt14;

  int checks = 0;
  int errors = 0;
  int fmode = 0;
  logic [15:0] ftab = 16'h0;
  logic rand_rdy4 = 1'b0, rand_rdy14 = 1'b0;
  logic [N4-1:0] q4[$];
  int busy_cycles4 = 0;

  minterm_scan_ctrl #(.N_IN(N4), .SETTLE(S4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .vec_out(vec4),
    .f_in(f4), .mt_valid(valid4), .mt_ready(ready4), .mt_index(idx4),
    .mt_count(cnt4), .busy(busy4), .done(done4));

  minterm_scan_ctrl #(.N_IN(N14), .SETTLE(S14)) dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .abort(abort14), .vec_out(vec14),
    .f_in(f14), .mt_valid(valid14), .mt_ready(ready14), .mt_index(idx14),
    .mt_count(cnt14), .busy(busy14), .done(done14));

  function automatic logic f4_of(input logic [N4-1:0] v);
    case (fmode)
      0:       return 1'b0;
      1:       return ^v;
      2:       return 1'b1;
      default: return ftab[v];
    endcase
  endfunction

  // Gate-level function under evaluation for the wide instance.
  function automatic logic f14_of(input logic [N14-1:0] v);
    return (v[3:0] == v[7:4]) || (&v[13:10]) || (v == 14'h1A5B);
  endfunction

  assign f4  = f4_of(vec4);
  assign f14 = f14_of(vec14);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Sweep-level model: position within the current vector's time slot plus pending minterm.
  typedef struct packed {
    logic          act;
    logic          valid;
    logic          done;
    logic          fin;
    logic [7:0]    age;
    logic [N4-1:0] vec;
    logic [N4-1:0] idx;
    logic [N4:0]   count;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic st, input logic ab, input logic rd);
    mstate_t n = s;
    logic sampling = !s.valid && (s.age == 8'(S4));
    if (s.fin) begin
      n.fin = 1'b0;
    end else if (!s.act) begin
      if (st && !ab) begin
        n.act = 1'b1; n.vec = '0; n.age = '0; n.count = '0; n.done = 1'b0;
      end
    end else if (ab) begin
      n.act = 1'b0; n.valid = 1'b0;
    end else if ((s.valid && rd) || (sampling && !f4_of(s.vec))) begin
      n.valid = 1'b0;
      if (s.vec == '1) begin
        n.act = 1'b0; n.done = 1'b1; n.fin = 1'b1;
      end else begin
        n.vec = s.vec + N4'(1); n.age = '0;
      end
    end else if (sampling) begin
      n.valid = 1'b1; n.idx = s.vec; n.count = s.count + (N4+1)'(1);
    end else if (!s.valid) begin
      n.age = s.age + 8'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, start4, abort4, ready4);
  end

  always @(negedge clk) begin
    chk("busy", busy4, m.act);
    chk("vec_out", vec4, m.vec);
    chk("mt_valid", valid4, m.valid);
    chk("mt_index", idx4, m.idx);
    chk("mt_count", cnt4, m.count);
    chk("done", done4, m.done);
    if (valid4 === 1'b1 && ready4) q4.push_back(idx4);
    if (busy4 === 1'b1) busy_cycles4++;
  end

  int exp14_ptr = 0, hs14 = 0, vcyc14 = 0, bcyc14 = 0;
  always @(negedge clk) begin
    if (busy14 === 1'b1) bcyc14++;
    if (valid14 === 1'b1) begin
      vcyc14++;
      chk("mt_index14_eq_vec", idx14, vec14);
      if (ready14) begin
        while (exp14_ptr < (1 << N14) && !f14_of(N14'(exp14_ptr))) exp14_ptr++;
        chk("mt_index14_stream", idx14, exp14_ptr);
        exp14_ptr++;
        hs14++;
      end
    end
  end

  always @(posedge clk) if (rand_rdy4) begin #1; ready4 = 1'($urandom_range(0, 1)); end
  always @(posedge clk) if (rand_rdy14) begin #1; ready14 = ($urandom_range(0, 3) != 0); end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start4();
    start4 = 1'b1; tick(1); start4 = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int limit);
    int n = 0;
    while (busy4 === 1'b1 && n < limit) begin tick(1); n++; end
    chk({name, "_busy_timeout"}, busy4, 0);
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n = 0;
    while (valid4 !== 1'b1 && n < limit) begin tick(1); n++; end
    chk({name, "_valid_timeout"}, valid4, 1);
  endtask

  task automatic wait_vec(input string name, input logic [N4-1:0] v, input int limit);
    int n = 0;
    while (vec4 !== v && n < limit) begin tick(1); n++; end
    chk({name, "_vec_timeout"}, vec4, v);
  endtask

  initial begin
    int exp3[8] = '{1, 2, 4, 7, 8, 11, 13, 14};
    int exp5[$];
    int tot14;

    tick(3);
    rst_n = 1'b1;
    chk("rst_vec_out", vec4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_mt_count", cnt4, 0);

    // Reset while a minterm is being offered
    fmode = 2; ready4 = 1'b0;
    pulse_start4();
    wait_valid("t1", 20);
    #2; rst_n = 1'b0; #1;
    chk("t1_async_valid", valid4, 0);
    chk("t1_async_busy", busy4, 0);
    chk("t1_async_count", cnt4, 0);
    chk("t1_async_vec", vec4, 0);
    chk("t1_async_index", idx4, 0);
    tick(2); rst_n = 1'b1;
    repeat (10) begin tick(1); chk("t1_no_valid_after_release", valid4, 0); end

    // Constant-zero function: pure sweep timing
    fmode = 0; q4.delete(); busy_cycles4 = 0;
    pulse_start4();
    wait_busy_low("t2", 200);
    tick(2);
    chk("t2_busy_cycles", busy_cycles4, 48);
    chk("t2_done", done4, 1);
    chk("t2_mt_count", cnt4, 0);
    chk("t2_vec_out", vec4, 4'hF);
    chk("t2_no_minterms", q4.size(), 0);

    // Odd parity, consumer always ready
    fmode = 1; ready4 = 1'b1; q4.delete();
    pulse_start4();
    wait_busy_low("t3", 200);
    tick(2);
    chk("t3_stream_len", q4.size(), 8);
    for (int i = 0; i < 8 && i < q4.size(); i++) chk("t3_stream_idx", q4[i], exp3[i]);
    chk("t3_mt_count", cnt4, 8);
    chk("t3_done", done4, 1);

    // Constant one with back-pressure on the first minterm
    fmode = 2; ready4 = 1'b0; q4.delete();
    pulse_start4();
    wait_valid("t4", 20);
    repeat (5) begin
      chk("t4_hold_valid", valid4, 1);
      chk("t4_hold_index", idx4, 0);
      chk("t4_hold_vec", vec4, 0);
      tick(1);
    end
    ready4 = 1'b1;
    wait_busy_low("t4", 200);
    tick(2);
    chk("t4_stream_len", q4.size(), 16);
    for (int i = 0; i < 16 && i < q4.size(); i++) chk("t4_stream_idx", q4[i], i);
    chk("t4_mt_count", cnt4, 16);

    // Random function, random ready, ignored start, abort, then restart
    fmode = 3; ftab = 16'($urandom) | 16'h0101; rand_rdy4 = 1'b1;
    for (int v = 0; v < 16; v++) if (ftab[v]) exp5.push_back(v);
    start4 = 1'b1; abort4 = 1'b1; tick(1); start4 = 1'b0; abort4 = 1'b0;
    chk("t5_abort_wins_in_idle", busy4, 0);
    pulse_start4();
    wait_vec("t5_mid", 4'd3, 200);
    start4 = 1'b1; tick(1); start4 = 1'b0;
    wait_vec("t5_abort_point", 4'd6, 200);
    abort4 = 1'b1; tick(1); abort4 = 1'b0;
    chk("t5_abort_busy", busy4, 0);
    chk("t5_abort_done", done4, 0);
    chk("t5_abort_vec", vec4, 6);
    chk("t5_abort_valid", valid4, 0);
    tick(3);
    q4.delete();
    pulse_start4();
    wait_busy_low("t5", 400);
    tick(2);
    chk("t5_stream_len", q4.size(), exp5.size());
    for (int i = 0; i < exp5.size() && i < q4.size(); i++) chk("t5_stream_idx", q4[i], exp5[i]);
    chk("t5_mt_count", cnt4, exp5.size());
    chk("t5_done", done4, 1);
    rand_rdy4 = 1'b0;

    // Full 14-input sweep of the gate netlist
    tot14 = 0;
    for (int v = 0; v < (1 << N14); v++) if (f14_of(N14'(v))) tot14++;
    chk("t6_truth_table_total", tot14, 1985);
    rand_rdy14 = 1'b1;
    tick(1);
    start14 = 1'b1; tick(1); start14 = 1'b0;
    begin
      int n = 0;
      while (busy14 === 1'b1 && n < 70000) begin tick(1); n++; end
    end
    chk("t6_busy_timeout", busy14, 0);
    tick(2);
    chk("t6_handshakes", hs14, tot14);
    chk("t6_mt_count", cnt14, tot14);
    chk("t6_vec_out", vec14, 14'h3FFF);
    chk("t6_done", done14, 1);
    chk("t6_busy_cycles", bcyc14, (1 << N14) * (S14 + 1) + vcyc14);
    rand_rdy14 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
